// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S transmitter, Philips timing, 16-bit stereo, one-entry sample buffer
module i2s_tx #(
  parameter int BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] audio_l,
  input  logic [15:0] audio_r,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        bclk,
  output logic        lrck,
  output logic        sdata,
  output logic        underrun
);

  localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

  logic [DW-1:0] r_div;
  logic [4:0]    r_p;
  logic [31:0]   r_shift;
  logic [31:0]   r_buf;
  logic          r_full;

  logic w_wrap;
  logic w_load;
  logic w_accept;

  assign w_wrap   = (r_div == DW'(BCLK_DIV - 1));
  assign w_load   = w_wrap && (r_p == 5'd0);
  assign w_accept = en && sample_valid && !r_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div   <= '0;
      r_p     <= '0;
      r_shift <= '0;
      r_buf   <= '0;
      r_full  <= 1'b0;
    end else if (!en) begin
      r_div   <= '0;
      r_p     <= '0;
      r_shift <= '0;
      r_buf   <= '0;
      r_full  <= 1'b0;
    end else begin
      r_div <= w_wrap ? '0 : r_div + DW'(1);
      if (w_wrap)
        r_p <= r_p + 5'd1;
      // Load replaces the shift at the end of period 0; the word's MSB then leads period 1.
      if (w_load)
        r_shift <= r_full ? r_buf : 32'd0;
      else if (w_wrap)
        r_shift <= {r_shift[30:0], 1'b0};
      // Accept needs an empty buffer and load only drains a full one, so these never collide.
      if (w_accept) begin
        r_buf  <= {audio_l, audio_r};
        r_full <= 1'b1;
      end else if (w_load) begin
        r_full <= 1'b0;
      end
    end
  end

  assign sample_ready = !en || !r_full;
  assign bclk         = (r_div >= DW'(BCLK_DIV / 2));
  assign lrck         = r_p[4];
  assign sdata        = r_shift[31];
  assign underrun     = en && w_load && !r_full;

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - directed self-checking bench for i2s_tx
module tb_i2s_tx;

  localparam int N = 400;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] audio_l = '0;
  logic [15:0] audio_r = '0;
  logic        sample_ready, bclk, lrck, sdata, underrun;

  int checks = 0;
  int failures = 0;

  logic        s_en [N];
  logic        s_v  [N];
  logic [15:0] s_l  [N];
  logic [15:0] s_r  [N];
  logic        c_bclk [N];
  logic        c_lrck [N];
  logic        c_sd   [N];
  logic        c_ur   [N];
  logic        c_rdy  [N];
  logic [31:0] fw [4];

  i2s_tx #(.BCLK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .audio_l(audio_l), .audio_r(audio_r), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .bclk(bclk), .lrck(lrck), .sdata(sdata),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Expected sdata in state k of an uninterrupted run; fw[f] is the word sent in frame f.
  function automatic logic exp_sd(int k);
    int f, p;
    f = k / 128;
    p = (k / 4) % 32;
    if (p == 0) return (f == 0) ? 1'b0 : fw[f-1][0];
    return fw[f][32-p];
  endfunction

  task automatic clear_sched();
    for (int k = 0; k < N; k++) begin
      s_en[k] = 1'b1; s_v[k] = 1'b0; s_l[k] = '0; s_r[k] = '0;
    end
    for (int f = 0; f < 4; f++) fw[f] = '0;
  endtask

  task automatic push(input int k, input logic [15:0] l, input logic [15:0] r);
    s_v[k] = 1'b1; s_l[k] = l; s_r[k] = r;
  endtask

  task automatic do_reset();
    en = 1'b0; sample_valid = 1'b0; reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // State k is the interval after the k-th rising edge; inputs for state k are applied at its start.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      en = s_en[k]; sample_valid = s_v[k]; audio_l = s_l[k]; audio_r = s_r[k];
      #1;
      c_bclk[k] = bclk; c_lrck[k] = lrck; c_sd[k] = sdata;
      c_ur[k] = underrun; c_rdy[k] = sample_ready;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    en = 1'b1; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bclk, lrck, sdata, underrun} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000", {bclk, lrck, sdata, underrun});
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", sample_ready);
    end
    en = 1'b0;
  endtask

  task automatic test_frame();
    int e_l, e_b, e_s, e_u;
    logic [15:0] v1, v2;
    do_reset();
    clear_sched();
    push(0, 16'h8001, 16'h7FFE);
    fw[0] = {16'h8001, 16'h7FFE};
    run(136);
    e_l = 0; e_b = 0; e_s = 0; e_u = 0;
    for (int k = 0; k < 136; k++) begin
      if (c_lrck[k] !== ((k % 128) >= 64)) e_l++;
      if (c_bclk[k] !== ((k % 4) >= 2)) e_b++;
      if (c_sd[k] !== exp_sd(k)) e_s++;
      if (c_ur[k] !== (k == 131)) e_u++;
    end
    v1 = '0; v2 = '0;
    for (int p = 1; p <= 16; p++) v1 = {v1[14:0], c_sd[4*p+1]};
    for (int p = 17; p <= 32; p++) v2 = {v2[14:0], c_sd[4*p+1]};
    checks++; if (e_l != 0) begin failures++; $display("FAIL frame_lrck errors=%0d exp=0", e_l); end
    checks++; if (e_b != 0) begin failures++; $display("FAIL frame_bclk errors=%0d exp=0", e_b); end
    checks++; if (e_s != 0) begin failures++; $display("FAIL frame_sdata errors=%0d exp=0", e_s); end
    checks++; if (e_u != 0) begin failures++; $display("FAIL frame_underrun errors=%0d exp=0", e_u); end
    checks++; if (v1 !== 16'h8001) begin failures++; $display("FAIL frame_left got=%h exp=8001", v1); end
    checks++; if (v2 !== 16'h7FFE) begin failures++; $display("FAIL frame_right got=%h exp=7ffe", v2); end
    checks++;
    if ({c_rdy[0], c_rdy[1], c_rdy[2], c_rdy[3], c_rdy[4]} !== 5'b10001) begin
      failures++;
      $display("FAIL frame_ready got=%b exp=10001",
               {c_rdy[0], c_rdy[1], c_rdy[2], c_rdy[3], c_rdy[4]});
    end
  endtask

  task automatic test_underrun_idle();
    int e_b, e_s, e_u, n_u;
    do_reset();
    clear_sched();
    run(300);
    e_b = 0; e_s = 0; e_u = 0; n_u = 0;
    for (int k = 0; k < 300; k++) begin
      if (c_bclk[k] !== ((k % 4) >= 2)) e_b++;
      if (c_sd[k] !== 1'b0) e_s++;
      if (c_ur[k] !== ((k % 128) == 3)) e_u++;
      if (c_ur[k] === 1'b1) n_u++;
    end
    checks++; if (e_b != 0) begin failures++; $display("FAIL idle_bclk errors=%0d exp=0", e_b); end
    checks++; if (e_s != 0) begin failures++; $display("FAIL idle_sdata errors=%0d exp=0", e_s); end
    checks++; if (e_u != 0) begin failures++; $display("FAIL idle_underrun_pos errors=%0d exp=0", e_u); end
    checks++; if (n_u != 3) begin failures++; $display("FAIL idle_underrun_count got=%0d exp=3", n_u); end
  endtask

  task automatic test_back_to_back();
    int e_s, e_u;
    do_reset();
    clear_sched();
    push(0, 16'h1234, 16'hABCD);
    for (int k = 1; k <= 4; k++) push(k, 16'hFEDC, 16'h0F0F);
    fw[0] = {16'h1234, 16'hABCD};
    fw[1] = {16'hFEDC, 16'h0F0F};
    run(264);
    e_s = 0; e_u = 0;
    for (int k = 0; k < 264; k++) begin
      if (c_sd[k] !== exp_sd(k)) e_s++;
      if (c_ur[k] !== (k == 259)) e_u++;
    end
    checks++;
    if ({c_rdy[0], c_rdy[1], c_rdy[2], c_rdy[3], c_rdy[4], c_rdy[5]} !== 6'b100010) begin
      failures++;
      $display("FAIL b2b_ready got=%b exp=100010",
               {c_rdy[0], c_rdy[1], c_rdy[2], c_rdy[3], c_rdy[4], c_rdy[5]});
    end
    checks++; if (e_s != 0) begin failures++; $display("FAIL b2b_sdata errors=%0d exp=0", e_s); end
    checks++; if (e_u != 0) begin failures++; $display("FAIL b2b_underrun errors=%0d exp=0", e_u); end
  endtask

  task automatic test_load_collision();
    int e_s, e_u;
    do_reset();
    clear_sched();
    push(3, 16'hC001, 16'h8003);
    fw[1] = {16'hC001, 16'h8003};
    run(264);
    e_s = 0; e_u = 0;
    for (int k = 0; k < 264; k++) begin
      if (c_sd[k] !== exp_sd(k)) e_s++;
      if (c_ur[k] !== (k == 3 || k == 259)) e_u++;
    end
    checks++;
    if ({c_rdy[3], c_rdy[4]} !== 2'b10) begin
      failures++;
      $display("FAIL coll_ready got=%b exp=10", {c_rdy[3], c_rdy[4]});
    end
    checks++; if (e_s != 0) begin failures++; $display("FAIL coll_sdata errors=%0d exp=0", e_s); end
    checks++; if (e_u != 0) begin failures++; $display("FAIL coll_underrun errors=%0d exp=0", e_u); end
  endtask

  task automatic test_en_abort();
    int e_pre, e_off, e_post, j;
    do_reset();
    clear_sched();
    push(0, 16'h1234, 16'hABCD);
    push(10, 16'h5555, 16'hAAAA);
    for (int k = 40; k < 50; k++) s_en[k] = 1'b0;
    push(45, 16'hFFFF, 16'hFFFF);
    fw[0] = {16'h1234, 16'hABCD};
    run(186);
    e_pre = 0; e_off = 0; e_post = 0;
    for (int k = 0; k < 40; k++) begin
      if (c_sd[k] !== exp_sd(k)) e_pre++;
      if (c_lrck[k] !== 1'b0 || c_bclk[k] !== ((k % 4) >= 2)) e_pre++;
    end
    for (int k = 41; k < 50; k++)
      if ({c_bclk[k], c_lrck[k], c_sd[k], c_ur[k], c_rdy[k]} !== 5'b00001) e_off++;
    for (int k = 50; k < 186; k++) begin
      j = k - 50;
      if (c_sd[k] !== 1'b0) e_post++;
      if (c_ur[k] !== ((j % 128) == 3)) e_post++;
      if (c_lrck[k] !== ((j % 128) >= 64)) e_post++;
      if (c_bclk[k] !== ((j % 4) >= 2)) e_post++;
    end
    checks++; if (c_rdy[40] !== 1'b1) begin failures++; $display("FAIL abort_ready_now got=%b exp=1", c_rdy[40]); end
    checks++; if (e_pre != 0) begin failures++; $display("FAIL abort_pre errors=%0d exp=0", e_pre); end
    checks++; if (e_off != 0) begin failures++; $display("FAIL abort_idle errors=%0d exp=0", e_off); end
    checks++; if (e_post != 0) begin failures++; $display("FAIL abort_restart errors=%0d exp=0", e_post); end
  endtask

  task automatic test_reset_mid();
    int e_u, e_s;
    do_reset();
    clear_sched();
    push(0, 16'h1234, 16'hABCD);
    push(4, 16'h5555, 16'hAAAA);
    run(71);
    checks++;
    if ({bclk, lrck, sdata, sample_ready} !== 4'b1110) begin
      failures++;
      $display("FAIL rstmid_before got=%b exp=1110", {bclk, lrck, sdata, sample_ready});
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bclk, lrck, sdata, underrun, sample_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL rstmid_async got=%b exp=00001", {bclk, lrck, sdata, underrun, sample_ready});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_sched();
    run(136);
    e_u = 0; e_s = 0;
    for (int k = 0; k < 136; k++) begin
      if (c_ur[k] !== ((k % 128) == 3)) e_u++;
      if (c_sd[k] !== 1'b0) e_s++;
    end
    checks++; if (e_u != 0) begin failures++; $display("FAIL rstmid_underrun errors=%0d exp=0", e_u); end
    checks++; if (e_s != 0) begin failures++; $display("FAIL rstmid_sdata errors=%0d exp=0", e_s); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_underrun_idle();
    test_back_to_back();
    test_load_collision();
    test_en_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
